// File: rtl/wti_cache_controller_if.sv
// rtl/wti_cache_controller_if.sv - CPU port and shared-bus signal bundle for the WTI cache controller.
interface wti_cache_controller_if #(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 16
);
   logic                     cpuRead;
   logic                     cpuWrite;
   logic [ADDRESS_WIDTH-1:0] cpuAddress;
   logic [DATA_WIDTH-1:0]    cpuDataOut;
   logic [DATA_WIDTH-1:0]    cpuDataIn;
   logic                     cpuFunctionComplete;
   logic                     busRequest;
   logic                     busGrant;
   logic                     busRead;
   logic                     busWrite;
   logic                     busInvalidate;
   logic [ADDRESS_WIDTH-1:0] busAddress;
   logic [DATA_WIDTH-1:0]    busDataOut;
   logic [DATA_WIDTH-1:0]    busDataIn;
   logic                     busAck;
   logic                     snoopInvalidate;
   logic [ADDRESS_WIDTH-1:0] snoopAddress;
   logic                     hit;

   modport master (
      input  cpuRead, cpuWrite, cpuAddress, cpuDataOut,
      input  busGrant, busDataIn, busAck, snoopInvalidate, snoopAddress,
      output cpuDataIn, cpuFunctionComplete, busRequest, busRead, busWrite,
      output busInvalidate, busAddress, busDataOut, hit
   );

   modport slave (
      output cpuRead, cpuWrite, cpuAddress, cpuDataOut,
      output busGrant, busDataIn, busAck, snoopInvalidate, snoopAddress,
      input  cpuDataIn, cpuFunctionComplete, busRequest, busRead, busWrite,
      input  busInvalidate, busAddress, busDataOut, hit
   );
endinterface

// File: rtl/wti_cache_controller.sv
// rtl/wti_cache_controller.sv - direct-mapped write-through-invalidate snoopy cache controller.
module wti_cache_controller #(
   parameter int ADDRESS_WIDTH  = 16,
   parameter int DATA_WIDTH     = 16,
   parameter int INDEX_WIDTH    = 4,
   parameter int WRITE_ALLOCATE = 0
) (
   input logic                     clock,
   input logic                     reset,
   wti_cache_controller_if.master  cache_if
);
   localparam int LINES     = 1 << INDEX_WIDTH;
   localparam int TAG_WIDTH = ADDRESS_WIDTH - INDEX_WIDTH;

   typedef enum logic [2:0] {IDLE, BUS_REQUEST, BUS_READ, BUS_WRITE, RESPOND} state_t;

   state_t                r_state;
   logic                  r_is_read;
   logic [LINES-1:0]      r_valid;
   logic [TAG_WIDTH-1:0]  r_tag  [LINES];
   logic [DATA_WIDTH-1:0] r_data [LINES];

   logic [INDEX_WIDTH-1:0] w_idx;
   logic [TAG_WIDTH-1:0]   w_tag;
   logic [INDEX_WIDTH-1:0] w_snp_idx;
   logic [TAG_WIDTH-1:0]   w_snp_tag;
   logic                   w_snoop_kill;
   logic                   w_line_match;
   logic                   w_lookup_hit;

   assign w_idx     = cache_if.cpuAddress[INDEX_WIDTH-1:0];
   assign w_tag     = cache_if.cpuAddress[ADDRESS_WIDTH-1:INDEX_WIDTH];
   assign w_snp_idx = cache_if.snoopAddress[INDEX_WIDTH-1:0];
   assign w_snp_tag = cache_if.snoopAddress[ADDRESS_WIDTH-1:INDEX_WIDTH];

   // A peer invalidate only counts while another master owns the bus.
   assign w_snoop_kill = cache_if.snoopInvalidate && !cache_if.busGrant &&
                         r_valid[w_snp_idx] && (r_tag[w_snp_idx] == w_snp_tag);
   assign w_line_match = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_lookup_hit = w_line_match && !(w_snoop_kill && (w_snp_idx == w_idx));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state                      <= IDLE;
         r_is_read                    <= 1'b0;
         r_valid                      <= '0;
         cache_if.cpuDataIn           <= '0;
         cache_if.cpuFunctionComplete <= 1'b0;
         cache_if.busRequest          <= 1'b0;
         cache_if.busRead             <= 1'b0;
         cache_if.busWrite            <= 1'b0;
         cache_if.busInvalidate       <= 1'b0;
         cache_if.busAddress          <= '0;
         cache_if.busDataOut          <= '0;
         cache_if.hit                 <= 1'b0;
      end else begin
         cache_if.hit                 <= 1'b0;
         cache_if.cpuFunctionComplete <= 1'b0;
         if (w_snoop_kill) begin
            r_valid[w_snp_idx] <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               if (cache_if.cpuRead || cache_if.cpuWrite) begin
                  r_is_read    <= cache_if.cpuRead;
                  cache_if.hit <= w_lookup_hit;
                  if (cache_if.cpuRead && w_lookup_hit) begin
                     r_state                      <= RESPOND;
                     cache_if.cpuFunctionComplete <= 1'b1;
                     cache_if.cpuDataIn           <= r_data[w_idx];
                  end else begin
                     r_state             <= BUS_REQUEST;
                     cache_if.busRequest <= 1'b1;
                  end
               end
            end
            BUS_REQUEST: begin
               if (cache_if.busGrant) begin
                  cache_if.busAddress <= cache_if.cpuAddress;
                  if (r_is_read) begin
                     r_state          <= BUS_READ;
                     cache_if.busRead <= 1'b1;
                  end else begin
                     r_state                <= BUS_WRITE;
                     cache_if.busWrite      <= 1'b1;
                     cache_if.busInvalidate <= 1'b1;
                     cache_if.busDataOut    <= cache_if.cpuDataOut;
                  end
               end
            end
            BUS_READ: begin
               if (cache_if.busAck) begin
                  r_valid[w_idx]               <= 1'b1;
                  r_tag[w_idx]                 <= w_tag;
                  r_data[w_idx]                <= cache_if.busDataIn;
                  cache_if.cpuDataIn           <= cache_if.busDataIn;
                  cache_if.busRead             <= 1'b0;
                  cache_if.busRequest          <= 1'b0;
                  cache_if.busAddress          <= '0;
                  cache_if.cpuFunctionComplete <= 1'b1;
                  r_state                      <= RESPOND;
               end
            end
            BUS_WRITE: begin
               if (cache_if.busAck) begin
                  // Hit status is re-evaluated here so a line snooped away while waiting is not revived.
                  if (w_line_match || (WRITE_ALLOCATE != 0)) begin
                     r_valid[w_idx] <= 1'b1;
                     r_tag[w_idx]   <= w_tag;
                     r_data[w_idx]  <= cache_if.cpuDataOut;
                  end
                  cache_if.busWrite            <= 1'b0;
                  cache_if.busInvalidate       <= 1'b0;
                  cache_if.busRequest          <= 1'b0;
                  cache_if.busAddress          <= '0;
                  cache_if.busDataOut          <= '0;
                  cache_if.cpuFunctionComplete <= 1'b1;
                  r_state                      <= RESPOND;
               end
            end
            RESPOND: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/wti_cache_controller.md
# wti_cache_controller

Parametrised write-through-invalidate snoopy cache controller for one CPU port. It holds a direct-mapped tag/state/data array and answers CPU reads and writes. Misses and all writes go over the shared bus through a request/grant/ack handshake. Each write also broadcasts an invalidate. Peer invalidates are snooped, and a matching local line drops to INVALID.

## Interface
- ADDRESS_WIDTH, default 16: CPU/bus address width; tag = ADDRESS_WIDTH − INDEX_WIDTH upper bits.
- DATA_WIDTH, default 16: word width; one word per line.
- INDEX_WIDTH, default 4: line count = 2^INDEX_WIDTH.
- WRITE_ALLOCATE, default 0: 1 = a write miss installs the line VALID with the written data; 0 = a write miss leaves the array untouched.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- cpuRead  in  1  read request; held until cpuFunctionComplete.
- cpuWrite  in  1  write request; held until cpuFunctionComplete.
- cpuAddress  in  ADDRESS_WIDTH  request address, stable while a request is held.
- cpuDataOut  in  DATA_WIDTH  write data from the CPU.
- cpuDataIn  out  DATA_WIDTH  read data to the CPU; valid with cpuFunctionComplete on a read.
- cpuFunctionComplete  out  1  one-cycle completion pulse.
- busRequest  out  1  bus ownership request.
- busGrant  in  1  arbiter grant.
- busRead  out  1  memory read command.
- busWrite  out  1  memory write command.
- busInvalidate  out  1  invalidate broadcast; asserted together with busWrite.
- busAddress  out  ADDRESS_WIDTH  bus command address.
- busDataOut  out  DATA_WIDTH  write data on the bus.
- busDataIn  in  DATA_WIDTH  fill data; sampled with busAck.
- busAck  in  1  memory completion for the current command.
- snoopInvalidate  in  1  a peer broadcasts an invalidate.
- snoopAddress  in  ADDRESS_WIDTH  address of the peer invalidate.
- hit  out  1  registered; high for one cycle when a lookup hits (statistics).

## Operation
- Line states: INVALID, VALID. DIRTY never occurs, because writes are always written through.
- FSM states: IDLE, BUS_REQUEST, BUS_READ, BUS_WRITE, RESPOND.
- IDLE: lookup on cpuAddress index, comparing the tag and requiring the line to be VALID.
  - Read hit → RESPOND.
  - Read miss → BUS_REQUEST.
  - Any write → BUS_REQUEST.
  - cpuRead and cpuWrite both high → treated as a read.
- BUS_REQUEST: busRequest=1. On busGrant, go to BUS_READ for a read or BUS_WRITE for a write.
- BUS_READ: busRead=1 and busAddress=cpuAddress. On busAck, latch busDataIn into the line, set tag, set VALID, go to RESPOND.
- BUS_WRITE: busWrite=busInvalidate=1, busAddress=cpuAddress, busDataOut=cpuDataOut. On busAck:
  - Write hit: update the data word; the line stays VALID.
  - Write miss with WRITE_ALLOCATE=1: install the line VALID.
  - Write miss with WRITE_ALLOCATE=0: no array change.
  - Then go to RESPOND.
- busRequest stays asserted from BUS_REQUEST through the busAck cycle inclusive.
- RESPOND: cpuFunctionComplete=1 for one cycle. cpuDataIn = the line data on a read. Next state IDLE.
  - A request still high in the following IDLE cycle is a new request. The CPU drops its request on complete.
- Snoop: when snoopInvalidate=1 and busGrant=0, a VALID line whose index and tag match snoopAddress becomes INVALID on the next edge.
  - Snoop is ignored while busGrant=1, because the bus is then owned by this cache.
  - Snoop in the same IDLE cycle as a lookup of the same line: the snoop applies and the lookup counts as a miss (the read goes to the bus).
  - Snoop during BUS_REQUEST against the pending line: the line is invalidated and the transaction is unaffected.
- Reset:
  - All lines INVALID; FSM IDLE.
  - All outputs 0, including busRequest, bus commands, cpuFunctionComplete, hit and cpuDataIn.
  - Reset mid-transaction aborts it. Outputs are 0 in the cycle after the reset edge, and no completion is issued.

## Timing
- Read hit: request seen in IDLE at edge N → hit=1 and cpuFunctionComplete=1 during cycle N+1. Latency 1.
- Miss or write, with busGrant already high:
  - busRequest rises in cycle N+1.
  - The command is driven from cycle N+2.
  - busAck in cycle M → completion in cycle M+1; busRequest and the command drop in cycle M+1.
- Every bus output is a registered FSM decode; there are no combinational paths from inputs to outputs.
- busAck outside BUS_READ and BUS_WRITE is ignored.

## Test plan
- Reset, then read 0x0012 (miss): busRead with busAddress=0x0012; ack with data 0xBEEF → cpuDataIn=0xBEEF with complete. A second read of 0x0012 completes 1 cycle after the request, with hit=1 and no busRequest.
- Write 0x0012 ← 0x1234 on a VALID line: busWrite=busInvalidate=1 and busDataOut=0x1234; after ack, a read of 0x0012 hits and returns 0x1234.
- Write miss 0x0034 with WRITE_ALLOCATE=0: bus write occurs and a later read of 0x0034 misses. With WRITE_ALLOCATE=1, the later read hits and returns the written data.
- Snoop 0x0012 while busGrant=0 → the next read of 0x0012 misses. Snoop 0x0112 (same index, different tag) → no effect, and the read hits.
- Snoop of 0x0012 in the same cycle as a CPU read of 0x0012 → the read goes to the bus. Snoop asserted while busGrant=1 → ignored.
- Reset asserted during BUS_READ, before busAck → busRequest=0 and busRead=0 the next cycle, no complete, and a subsequent read of the same address misses.
